tlul_brq_host_adapter: RTL and testbench

- Bridges the core's simple load/store port (req/gnt/rvalid) onto a TileLink-UL host interface.
- Sits directly upstream of the main crossbar: one instance each for the instruction-fetch and LSU host ports.
- Generates TL-UL opcode, mask and source ID, and tracks up to MAX_REQS in-flight transactions.
- Returns registered, in-order responses to the core.

---
 rtl/tlul_pkg.sv | 57 +++++
 rtl/tlul_brq_host_adapter.sv | 143 ++++++++++++++
 tb/tb_tlul_brq_host_adapter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// TileLink-UL bus types shared by the crossbar and its host adapters.
// Provides the A/D opcode enumerations, the host-to-device and
// device-to-host channel structs, and the shared outstanding-request depth.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;  // address width
  localparam int unsigned TL_DW  = 32;  // data width
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;   // size field width
  localparam int unsigned TL_AIW = 8;   // source id width
  localparam int unsigned TL_DIW = 1;   // sink id width
  localparam int unsigned TL_AUW = 16;  // A-channel user width
  localparam int unsigned TL_DUW = 16;  // D-channel user width

  // Outstanding depth agreed between the crossbar and every host adapter.
  localparam int unsigned TL_BRQ_MAX_REQS = 2;

  localparam logic [TL_AUW-1:0] TL_A_USER_DEFAULT = '0;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_AUW-1:0]   a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_DUW-1:0]   d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_brq_host_adapter.sv
// Bridges the core's req/gnt/rvalid load-store port onto a TL-UL host port.
// Builds the A-channel beat combinationally from the core request, tracks up
// to MAX_REQS outstanding transactions and returns registered, in-order
// responses.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   req_i/gnt_o             core request handshake (gnt_o is combinational)
//   addr_i/we_i/be_i/wdata_i core request payload
//   valid_o/rdata_o/err_o   registered one-cycle response
//   tl_o / tl_i             TL-UL host-to-device / device-to-host channels
//
// Optional feature: define BRQ_ADAPTER_SRC_CHECK_EN to compare each returned
// d_source against the expected in-order source id and flag mismatches as
// errors.
module tlul_brq_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned MAX_REQS = TL_BRQ_MAX_REQS
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int unsigned CntW = $clog2(MAX_REQS) + 1;
  localparam int unsigned SrcW = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;

  logic [CntW-1:0] outst_q, outst_d;
  logic [SrcW-1:0] wr_src_q, wr_src_d;
  logic            valid_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic a_valid, a_fire, d_fire, src_err;

  // Requests are masked during reset so nothing is granted into a cleared pipe.
  assign a_valid = rst_ni && req_i && (outst_q < CntW'(MAX_REQS));
  assign a_fire  = a_valid && tl_i.a_ready;
  assign d_fire  = tl_i.d_valid && (outst_q != '0);
  assign gnt_o   = a_fire;

  // A-channel beat and constant d_ready.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = !we_i ? Get : ((be_i == 4'hF) ? PutFullData : PutPartialData);
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = TL_SZW'(2);
    tl_o.a_source  = TL_AIW'(wr_src_q);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : 4'hF;
    tl_o.a_data    = we_i ? wdata_i : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  // Outstanding counter and write-side source id.
  always_comb begin
    outst_d  = outst_q;
    wr_src_d = wr_src_q;
    unique case ({a_fire, d_fire})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase
    if (a_fire) begin
      wr_src_d = (wr_src_q == SrcW'(MAX_REQS - 1)) ? '0 : wr_src_q + SrcW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q  <= '0;
      wr_src_q <= '0;
    end else begin
      outst_q  <= outst_d;
      wr_src_q <= wr_src_d;
    end
  end

`ifdef BRQ_ADAPTER_SRC_CHECK_EN
  // Read-side expected source id; responses come back in issue order.
  logic [SrcW-1:0] rd_src_q, rd_src_d;

  always_comb begin
    rd_src_d = rd_src_q;
    if (d_fire) begin
      rd_src_d = (rd_src_q == SrcW'(MAX_REQS - 1)) ? '0 : rd_src_q + SrcW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_src_q <= '0;
    end else begin
      rd_src_q <= rd_src_d;
    end
  end

  assign src_err = (tl_i.d_source != TL_AIW'(rd_src_q));

  logic unused_tl_i;
  assign unused_tl_i = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                         tl_i.d_sink, tl_i.d_user};
`else
  assign src_err = 1'b0;

  logic unused_tl_i;
  assign unused_tl_i = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                         tl_i.d_sink, tl_i.d_user, tl_i.d_source};
`endif

  // Response registers; data and error hold between pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= d_fire;
      if (d_fire) begin
        rdata_q <= tl_i.d_data;
        err_q   <= tl_i.d_error | src_err;
      end
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_tlul_brq_host_adapter.sv
// Self-checking bench for tlul_brq_host_adapter: directed scenarios followed
// by randomized traffic, all checked against a queue-based reference model
// of the outstanding transactions.
module tb_tlul_brq_host_adapter;
  import tlul_pkg::*;

  localparam int unsigned MAX = TL_BRQ_MAX_REQS;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  tl_h2d_t     tl_h;
  tl_d2h_t     tl_d;

  tlul_brq_host_adapter #(.MAX_REQS(MAX)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .wdata_i (wdata_i),
    .valid_o (valid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .tl_o    (tl_h),
    .tl_i    (tl_d)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the slave's view of accepted, not-yet-answered requests.
  int          src_q[$];
  bit          we_q[$];
  int          wr_cnt;
  int          rd_cnt;
  bit          exp_v;
  logic [31:0] exp_rdata;
  bit          exp_err;
  bit          a_fired;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    src_q.delete();
    we_q.delete();
    wr_cnt    = 0;
    rd_cnt    = 0;
    exp_v     = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    a_fired   = 1'b0;
  endtask

  task automatic set_req(input bit r, input bit we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    req_i   = r;
    we_i    = we;
    addr_i  = a;
    be_i    = be;
    wdata_i = wd;
  endtask

  task automatic set_d(input bit v, input logic [31:0] data, input bit err, input int src);
    tl_d.d_valid  = v;
    tl_d.d_data   = data;
    tl_d.d_error  = err;
    tl_d.d_source = 8'(src);
    tl_d.d_opcode = AccessAckData;
  endtask

  // One clock: check everything against the model mid-cycle, advance model.
  task automatic step();
    bit        av;
    bit        d_fire;
    tl_a_op_e  exp_op;
    @(negedge clk_i);
    av = req_i && (src_q.size() < MAX);
    chk_eq("a_valid", tl_h.a_valid, av);
    chk_eq("gnt", gnt_o, av && tl_d.a_ready);
    chk_eq("outst", 32'(dut.outst_q), src_q.size());
    chk_eq("d_ready", tl_h.d_ready, 1'b1);
    if (av) begin
      exp_op = we_i ? ((be_i == 4'hF) ? PutFullData : PutPartialData) : Get;
      chk_eq("opcode", 32'(tl_h.a_opcode), 32'(exp_op));
      chk_eq("address", tl_h.a_address, addr_i & 32'hFFFF_FFFC);
      chk_eq("mask", tl_h.a_mask, we_i ? be_i : 4'hF);
      chk_eq("data", tl_h.a_data, we_i ? wdata_i : 32'h0);
      chk_eq("source", tl_h.a_source, wr_cnt % MAX);
      chk_eq("size", tl_h.a_size, 2);
      chk_eq("param", tl_h.a_param, 0);
      chk_eq("user", tl_h.a_user, TL_A_USER_DEFAULT);
    end
    chk_eq("valid_o", valid_o, exp_v);
    chk_eq("rdata_o", rdata_o, exp_rdata);
    chk_eq("err_o", err_o, exp_err);

    d_fire = tl_d.d_valid && (src_q.size() > 0);
    exp_v  = d_fire;
    if (d_fire) begin
      exp_rdata = tl_d.d_data;
      exp_err   = tl_d.d_error;
`ifdef BRQ_ADAPTER_SRC_CHECK_EN
      if (tl_d.d_source != 8'(rd_cnt % MAX)) exp_err = 1'b1;
`endif
      rd_cnt++;
      void'(src_q.pop_front());
      void'(we_q.pop_front());
    end
    a_fired = av && tl_d.a_ready;
    if (a_fired) begin
      src_q.push_back(wr_cnt % MAX);
      we_q.push_back(we_i);
      wr_cnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_d(1'b0, '0, 1'b0, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drive_random();
    if (!(req_i && !a_fired)) begin
      req_i   = ($urandom_range(0, 3) != 0);
      we_i    = 1'($urandom_range(0, 1));
      addr_i  = $urandom;
      be_i    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      wdata_i = $urandom;
    end
    tl_d.a_ready = ($urandom_range(0, 3) != 0);
    if (src_q.size() > 0 && $urandom_range(0, 2) != 0)
      set_d(1'b1, we_q[0] ? 32'h0 : $urandom, ($urandom_range(0, 7) == 0), src_q[0]);
    else if (src_q.size() == 0 && $urandom_range(0, 9) == 0)
      set_d(1'b1, $urandom, 1'b1, 3);
    else
      set_d(1'b0, $urandom, 1'($urandom_range(0, 1)), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tl_d = '0;
    model_reset();
    // Reset: request held with a_ready high must not be granted.
    set_req(1'b1, 1'b0, 32'h1000_0000, 4'h0, '0);
    tl_d.a_ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_eq("rst_gnt", gnt_o, 1'b0);
    chk_eq("rst_a_valid", tl_h.a_valid, 1'b0);
    chk_eq("rst_valid", valid_o, 1'b0);
    chk_eq("rst_rdata", rdata_o, 32'h0);
    chk_eq("rst_err", err_o, 1'b0);
    req_i  = 1'b0;
    rst_ni = 1'b1;

    // Single load with an unaligned address.
    set_req(1'b1, 1'b0, 32'h1000_0006, 4'h0, '0);
    #1;
    chk_eq("ld_gnt", gnt_o, 1'b1);
    chk_eq("ld_addr", tl_h.a_address, 32'h1000_0004);
    chk_eq("ld_mask", tl_h.a_mask, 4'hF);
    chk_eq("ld_op", 32'(tl_h.a_opcode), 32'(Get));
    chk_eq("ld_src", tl_h.a_source, 0);
    step();
    req_i = 1'b0;
    set_d(1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    step();
    set_d(1'b0, '0, 1'b0, 0);
    chk_eq("ld_valid", valid_o, 1'b1);
    chk_eq("ld_rdata", rdata_o, 32'hDEAD_BEEF);
    chk_eq("ld_err", err_o, 1'b0);
    step();
    chk_eq("ld_pulse", valid_o, 1'b0);

    // Full-word and partial stores.
    set_req(1'b1, 1'b1, 32'h2000_0000, 4'hF, 32'h1234_5678);
    #1;
    chk_eq("stf_op", 32'(tl_h.a_opcode), 32'(PutFullData));
    chk_eq("stf_mask", tl_h.a_mask, 4'hF);
    chk_eq("stf_data", tl_h.a_data, 32'h1234_5678);
    step();
    req_i = 1'b0;
    set_d(1'b1, 32'h0, 1'b0, 1);
    step();
    set_d(1'b0, '0, 1'b0, 0);
    chk_eq("stf_valid", valid_o, 1'b1);
    step();
    set_req(1'b1, 1'b1, 32'h2000_0008, 4'b0011, 32'hA5A5_5A5A);
    #1;
    chk_eq("stp_op", 32'(tl_h.a_opcode), 32'(PutPartialData));
    chk_eq("stp_mask", tl_h.a_mask, 4'b0011);
    step();
    req_i = 1'b0;
    set_d(1'b1, 32'h0, 1'b0, 0);
    step();
    set_d(1'b0, '0, 1'b0, 0);
    chk_eq("stp_valid", valid_o, 1'b1);
    step();

    // Backpressure: fill, stall, release one response, then A+D together.
    apply_reset();
    tl_d.a_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h3000_0000, 4'h0, '0);
    #1;
    chk_eq("full_src0", tl_h.a_source, 0);
    step();
    addr_i = 32'h3000_0004;
    #1;
    chk_eq("full_gnt1", gnt_o, 1'b1);
    chk_eq("full_src1", tl_h.a_source, 1);
    step();
    addr_i = 32'h3000_0008;
    #1;
    chk_eq("full_gnt_blocked", gnt_o, 1'b0);
    step();
    set_d(1'b1, 32'h0000_0011, 1'b0, 0);
    #1;
    chk_eq("full_gnt_same_cycle", gnt_o, 1'b0);
    step();
    set_d(1'b1, 32'h0000_0022, 1'b0, 1);
    #1;
    chk_eq("full_gnt_next", gnt_o, 1'b1);
    chk_eq("full_src_wrap", tl_h.a_source, 0);
    step();
    req_i = 1'b0;
    set_d(1'b0, '0, 1'b0, 0);
    chk_eq("both_fire_outst", 32'(dut.outst_q), 1);
    step();
    set_d(1'b1, 32'h0000_0033, 1'b0, 0);
    step();
    set_d(1'b0, '0, 1'b0, 0);
    step();

    // Slave error.
    apply_reset();
    tl_d.a_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h4000_0000, 4'h0, '0);
    step();
    req_i = 1'b0;
    set_d(1'b1, 32'hCAFE_0000, 1'b1, 0);
    step();
    set_d(1'b0, '0, 1'b0, 0);
    chk_eq("derr_err", err_o, 1'b1);
    step();

    // Wrong d_source on the first response after reset.
    apply_reset();
    tl_d.a_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h4000_0010, 4'h0, '0);
    step();
    req_i = 1'b0;
    set_d(1'b1, 32'h5555_AAAA, 1'b0, 1);
    step();
    set_d(1'b0, '0, 1'b0, 0);
`ifdef BRQ_ADAPTER_SRC_CHECK_EN
    chk_eq("srcchk_err", err_o, 1'b1);
`else
    chk_eq("srcchk_err", err_o, 1'b0);
`endif
    chk_eq("srcchk_rdata", rdata_o, 32'h5555_AAAA);
    step();

    // Randomized traffic.
    apply_reset();
    repeat (2000) begin
      drive_random();
      step();
    end

    // Reset mid-flight with two requests outstanding and an error held.
    apply_reset();
    tl_d.a_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h5000_0000, 4'h0, '0);
    step();
    req_i = 1'b0;
    set_d(1'b1, 32'h0000_0077, 1'b1, 0);
    step();
    set_d(1'b0, '0, 1'b0, 0);
    set_req(1'b1, 1'b0, 32'h5000_0004, 4'h0, '0);
    step();
    addr_i = 32'h5000_0008;
    step();
    chk_eq("mid_outst", 32'(dut.outst_q), 2);
    chk_eq("mid_rdata_held", rdata_o, 32'h0000_0077);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_eq("mid_gnt", gnt_o, 1'b0);
    chk_eq("mid_a_valid", tl_h.a_valid, 1'b0);
    chk_eq("mid_valid", valid_o, 1'b0);
    chk_eq("mid_rdata", rdata_o, 32'h0);
    chk_eq("mid_err", err_o, 1'b0);
    chk_eq("mid_outst_clr", 32'(dut.outst_q), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    req_i  = 1'b0;
    set_d(1'b1, 32'h0000_0099, 1'b0, 0);
    step();
    step();
    chk_eq("stale_valid", valid_o, 1'b0);
    set_d(1'b0, '0, 1'b0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
